// File: rtl/hamming_decode.sv
`default_nettype none
// ============================================================================
// Module   : hamming_decode
// Purpose  : SECDED (extended Hamming) decoder. Recomputes syndrome and overall
//            parity of a received code word, corrects any single-bit error,
//            flags double-bit errors, extracts the payload and keeps two
//            saturating error counters. Two register stages, full throughput.
// Ports    : clk_i                 - clock, rising edge
//            rst_n_i               - asynchronous active-low reset
//            data_in_i             - code word (bit 0 overall parity,
//                                    bits 2**k Hamming parity, rest payload
//                                    LSB-first, unused high positions pad)
//            valid_in_i            - data_in_i valid this cycle
//            clear_counts_i        - synchronous clear of both counters
//            data_out_o            - corrected payload
//            valid_out_o           - outputs valid this cycle
//            single_err_o          - single-bit error corrected
//            double_err_o          - uncorrectable double-bit error
//            err_pos_o             - corrected bit index (0 if none)
//            corrected_count_o     - saturating count of single-error words
//            uncorrectable_count_o - saturating count of double-error words
// Revision : 1.0 - initial release
// ============================================================================
module hamming_decode #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int COUNT_WIDTH = 16,
  // Smallest r with 2**r - r - 1 >= DATA_WIDTH; it is always either
  // clog2(DATA_WIDTH+1) or one more than that.
  localparam int ADDR_WIDTH  =
    (((2 ** $clog2(DATA_WIDTH + 1)) - $clog2(DATA_WIDTH + 1) - 1) >= DATA_WIDTH)
      ? $clog2(DATA_WIDTH + 1) : ($clog2(DATA_WIDTH + 1) + 1),
  localparam int CODED_WIDTH = 2 ** ADDR_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [CODED_WIDTH-1:0] data_in_i,
  input  logic                   valid_in_i,
  input  logic                   clear_counts_i,
  output logic [DATA_WIDTH-1:0]  data_out_o,
  output logic                   valid_out_o,
  output logic                   single_err_o,
  output logic                   double_err_o,
  output logic [ADDR_WIDTH-1:0]  err_pos_o,
  output logic [COUNT_WIDTH-1:0] corrected_count_o,
  output logic [COUNT_WIDTH-1:0] uncorrectable_count_o
);

  // Code-word index carrying payload bit j: the j-th index >= 1 that is not
  // a power of two.
  function automatic int data_pos(input int j);
    int k;
    data_pos = 0;
    k = 0;
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (k == j) data_pos = i;
        k++;
      end
    end
  endfunction

  // --------------------------------------------------------------------------
  // Stage 1: input register
  // --------------------------------------------------------------------------
  logic [CODED_WIDTH-1:0] r_word1;
  logic                   r_v1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_word1 <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_v1 <= valid_in_i;
      if (valid_in_i) r_word1 <= data_in_i;
    end
  end

  // --------------------------------------------------------------------------
  // Decode logic on the stage-1 word
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_syn;
  logic                  w_pmis;
  logic                  w_single;
  logic                  w_double;
  logic                  w_flip_en;
  logic [ADDR_WIDTH-1:0] w_pos;
  logic [DATA_WIDTH-1:0] w_payload;

  // Syndrome is the XOR of the indices of all set bits; zero for a valid word.
  always_comb begin
    w_syn = '0;
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if (r_word1[i]) w_syn = w_syn ^ i[ADDR_WIDTH-1:0];
    end
  end

  assign w_pmis    = ^r_word1;
  assign w_single  = w_pmis;
  assign w_double  = (w_syn != '0) && !w_pmis;
  // An odd error with syn=0 sits in bit 0, which carries no payload.
  assign w_flip_en = w_pmis && (w_syn != '0);
  assign w_pos     = w_pmis ? w_syn : '0;

  // Payload extraction; only the bit addressed by the syndrome is flipped.
  // Double errors pass through uncorrected because w_flip_en is low.
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_extract
    localparam int c_POS = data_pos(j);
    assign w_payload[j] = r_word1[c_POS] ^
                          (w_flip_en && (w_syn == ADDR_WIDTH'(c_POS)));
  end

  // --------------------------------------------------------------------------
  // Stage 2: output registers (hold last value while valid is low)
  // --------------------------------------------------------------------------
  logic                  r_v2;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_serr;
  logic                  r_derr;
  logic [ADDR_WIDTH-1:0] r_pos;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v2   <= 1'b0;
      r_data <= '0;
      r_serr <= 1'b0;
      r_derr <= 1'b0;
      r_pos  <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data <= w_payload;
        r_serr <= w_single;
        r_derr <= w_double;
        r_pos  <= w_pos;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating error counters; update on the edge that loads stage 2.
  // Clear wins over a coincident increment.
  // --------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] r_cnt_corr;
  logic [COUNT_WIDTH-1:0] r_cnt_unc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (clear_counts_i) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (r_v1) begin
      if (w_single && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + COUNT_WIDTH'(1);
      if (w_double && (r_cnt_unc  != '1)) r_cnt_unc  <= r_cnt_unc  + COUNT_WIDTH'(1);
    end
  end

  assign data_out_o            = r_data;
  assign valid_out_o           = r_v2;
  assign single_err_o          = r_serr;
  assign double_err_o          = r_derr;
  assign err_pos_o             = r_pos;
  assign corrected_count_o     = r_cnt_corr;
  assign uncorrectable_count_o = r_cnt_unc;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_decode
// Purpose  : Directed self-checking bench for hamming_decode. A 16-bit-counter
//            instance covers decode behaviour; a 2-bit-counter instance shares
//            the same stimulus and covers counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        clear_counts = 1'b0;

  logic [31:0] data_out, s_data_out;
  logic        valid_out, s_valid_out;
  logic        serr, s_serr, derr, s_derr;
  logic [5:0]  pos, s_pos;
  logic [15:0] corr, unc;
  logic [1:0]  s_corr, s_unc;

  int n_vec = 0;
  int n_err = 0;
  int exp_corr = 0;
  int exp_unc = 0;

  always #5 clk = ~clk;

  hamming_decode #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(data_in), .valid_in_i(valid_in),
    .clear_counts_i(clear_counts), .data_out_o(data_out), .valid_out_o(valid_out),
    .single_err_o(serr), .double_err_o(derr), .err_pos_o(pos),
    .corrected_count_o(corr), .uncorrectable_count_o(unc)
  );

  hamming_decode #(.DATA_WIDTH(32), .COUNT_WIDTH(2)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .data_in_i(data_in), .valid_in_i(valid_in),
    .clear_counts_i(clear_counts), .data_out_o(s_data_out), .valid_out_o(s_valid_out),
    .single_err_o(s_serr), .double_err_o(s_derr), .err_pos_o(s_pos),
    .corrected_count_o(s_corr), .uncorrectable_count_o(s_unc)
  );

  // Stimulus encoder: payload into non-power-of-two positions, Hamming parity
  // at 2**b so the syndrome is zero, then overall parity in bit 0.
  function automatic logic [63:0] encode(input logic [31:0] d);
    logic [63:0] w;
    logic        p;
    int          k;
    w = '0;
    k = 0;
    for (int i = 1; i < 64; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (k < 32) w[i] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      p = 1'b0;
      for (int i = 1; i < 64; i++)
        if ((((i >> b) & 1) == 1) && (i != (1 << b))) p = p ^ w[i];
      w[1 << b] = p;
    end
    w[0] = ^w[63:1];
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_out); end
    n_vec++; if ({serr, derr} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {serr, derr}); end
    n_vec++; if (pos !== 6'd0) begin n_err++; $display("FAIL reset_pos got %0d want 0", pos); end
    n_vec++; if ({corr, unc} !== 32'h0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", corr, unc); end
    rst_n = 1'b1;
    exp_corr = 0;
    exp_unc  = 0;
  endtask

  // One word through the pipe: latency and every output checked inline.
  task automatic test_single_word(input string name, input logic [31:0] d,
                                  input logic [63:0] flip, input logic [31:0] exp_data,
                                  input logic exp_s, input logic exp_d,
                                  input logic [5:0] exp_pos);
    @(negedge clk);
    data_in  = encode(d) ^ flip;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL %s early_valid got %b want 0", name, valid_out); end
    @(negedge clk);
    if (exp_s) exp_corr++;
    if (exp_d) exp_unc++;
    n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL %s valid got %b want 1", name, valid_out); end
    n_vec++; if (data_out !== exp_data) begin n_err++; $display("FAIL %s data got %h want %h", name, data_out, exp_data); end
    n_vec++; if (serr !== exp_s) begin n_err++; $display("FAIL %s single_err got %b want %b", name, serr, exp_s); end
    n_vec++; if (derr !== exp_d) begin n_err++; $display("FAIL %s double_err got %b want %b", name, derr, exp_d); end
    n_vec++; if (pos !== exp_pos) begin n_err++; $display("FAIL %s err_pos got %0d want %0d", name, pos, exp_pos); end
    n_vec++; if (corr !== 16'(exp_corr)) begin n_err++; $display("FAIL %s corrected got %0d want %0d", name, corr, exp_corr); end
    n_vec++; if (unc !== 16'(exp_unc)) begin n_err++; $display("FAIL %s uncorrectable got %0d want %0d", name, unc, exp_unc); end
    @(negedge clk);
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL %s valid_drop got %b want 0", name, valid_out); end
    n_vec++; if (data_out !== exp_data) begin n_err++; $display("FAIL %s data_hold got %h want %h", name, data_out, exp_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [63:0] flips [4];
    words = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
    flips = '{64'h0, 64'h1 << 20, 64'h0, 64'h0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 6) begin
        n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", c - 2, valid_out); end
        n_vec++; if (data_out !== words[c-2]) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", c - 2, data_out, words[c-2]); end
        n_vec++; if (serr !== (c == 3)) begin n_err++; $display("FAIL b2b_serr[%0d] got %b want %b", c - 2, serr, (c == 3)); end
      end
      if (c == 6) begin
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_tail_valid got %b want 0", valid_out); end
      end
      if (c < 4) begin
        data_in  = encode(words[c]) ^ flips[c];
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    exp_corr++;
    n_vec++; if (corr !== 16'(exp_corr)) begin n_err++; $display("FAIL b2b_corrected got %0d want %0d", corr, exp_corr); end
  endtask

  task automatic test_saturate();
    test_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 5 || c == 6) begin
        n_vec++; if (s_corr !== 2'd3) begin n_err++; $display("FAIL sat_count[%0d] got %0d want 3", c, s_corr); end
      end
      if (c < 5) begin
        data_in  = encode(32'h1234_5678) ^ (64'h1 << 7);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    n_vec++; if (corr !== 16'd5) begin n_err++; $display("FAIL sat_wide_count got %0d want 5", corr); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    data_in  = encode(32'h0F0F_0F0F) ^ (64'h1 << 9);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in     = 1'b0;
    clear_counts = 1'b1;   // same edge as the counter increment
    @(negedge clk);
    clear_counts = 1'b0;
    n_vec++; if (s_valid_out !== 1'b1 || s_serr !== 1'b1) begin n_err++; $display("FAIL clr_word got v=%b s=%b want 1/1", s_valid_out, s_serr); end
    n_vec++; if (s_corr !== 2'd0) begin n_err++; $display("FAIL clr_small_count got %0d want 0", s_corr); end
    n_vec++; if (corr !== 16'd0) begin n_err++; $display("FAIL clr_wide_count got %0d want 0", corr); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    data_in  = encode(32'hCAFE_0001);
    valid_in = 1'b1;
    @(negedge clk);
    data_in  = encode(32'hCAFE_0002);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", valid_out); end
    n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL rst_async_data got %h want 0", data_out); end
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++; if (valid_out !== 1'b0 || s_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_flush[%0d] got %b/%b want 0/0", c, valid_out, s_valid_out); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word("clean",   32'hDEADBEEF, 64'h0,                      32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
    test_single_word("bit5",    32'hDEADBEEF, 64'h1 << 5,                 32'hDEADBEEF, 1'b1, 1'b0, 6'd5);
    test_single_word("bit0",    32'hDEADBEEF, 64'h1,                      32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
    // positions 3 and 10 hold payload bits 0 and 5, extracted uncorrected
    test_single_word("double",  32'hDEADBEEF, (64'h1 << 3) | (64'h1 << 10), 32'hDEADBECE, 1'b0, 1'b1, 6'd0);
    // position 50 is a pad bit (payload ends at position 38)
    test_single_word("pad50",   32'hDEADBEEF, 64'h1 << 50,                32'hDEADBEEF, 1'b1, 1'b0, 6'd50);
    // position 38 carries payload bit 31
    test_single_word("msb38",   32'h8000_0000, 64'h1 << 38,               32'h8000_0000, 1'b1, 1'b0, 6'd38);
    test_back_to_back();
    test_saturate();
    test_clear();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
